// File: rtl/icache_ram_block_pkg.sv
// Shared process-config and stddef definitions for the icache RAM block.
// Provides ProcessConf_t, DEFAULT_PROCESS and the Enable_/Read/Write levels.
package icache_ram_block_pkg;

    typedef enum logic [1:0] {
        GENERIC   = 2'd0,
        XILINX_7  = 2'd1,
        XILINX_U  = 2'd2,
        XILINX_UP = 2'd3
    } ProcessConf_t;

    localparam ProcessConf_t DEFAULT_PROCESS = GENERIC;

    localparam logic Enable_  = 1'b0;
    localparam logic Disable_ = 1'b1;
    localparam logic Read     = 1'b1;
    localparam logic Write    = 1'b0;
    localparam logic Low      = 1'b0;

endpackage

// File: rtl/icache_ram_block_model.sv
// Generic single-port line RAM with a registered read port.
// Ports: clk, reset (sync, high), en_ (low), rw_, addr, wdata, rdata.
module ic_ram_model
    import icache_ram_block_pkg::*;
#(
    parameter int LINE  = 128,
    parameter int DEPTH = 1024,
    localparam int ADDR = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en_,
    input  logic            rw_,
    input  logic [ADDR-1:0] addr,
    input  logic [LINE-1:0] wdata,
    output logic [LINE-1:0] rdata
);

    logic [LINE-1:0] r_mem [DEPTH];
    logic [LINE-1:0] r_rdata;
    logic            w_in_range;
    logic            w_acc;

    // Only matters for non-power-of-two DEPTH.
    assign w_in_range = (int'(addr) < DEPTH);
    assign w_acc      = (en_ == Enable_) && !reset;

    always_ff @(posedge clk) begin
        if (w_acc && rw_ == Write && w_in_range) begin
            r_mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= {LINE{Low}};
        end else if (w_acc && rw_ == Read) begin
            r_rdata <= w_in_range ? r_mem[addr] : {LINE{Low}};
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/icache_ram_block.sv
// One way/bank of the icache data/tag array; picks the RAM implementation.
// Ports: clk, reset, en_, rw_, addr, wdata, rdata. Macro: IC_RAM_XPM_EN.
module icache_ram_block
    import icache_ram_block_pkg::*;
#(
    parameter int           LINE    = 128,
    parameter int           DEPTH   = 1024,
    parameter ProcessConf_t PROCESS = DEFAULT_PROCESS,
    localparam int          ADDR    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en_,
    input  logic            rw_,
    input  logic [ADDR-1:0] addr,
    input  logic [LINE-1:0] wdata,
    output logic [LINE-1:0] rdata
);

`ifdef IC_RAM_XPM_EN
    if (PROCESS == XILINX_7 || PROCESS == XILINX_U ||
        PROCESS == XILINX_UP) begin : g_xpm
        localparam string PRIM =
            (PROCESS == XILINX_UP) ? "ultra" : "block";

        logic            w_in_range;
        logic            w_ena;
        logic            w_wea;
        logic            r_oor;
        logic [LINE-1:0] w_douta;

        assign w_in_range = (int'(addr) < DEPTH);
        // Keep the port enabled during reset so rsta clears douta.
        assign w_ena = (en_ == Enable_) || reset;
        assign w_wea = (en_ == Enable_) && (rw_ == Write) &&
                       !reset && w_in_range;

        // Vendor RAM output is undefined past DEPTH; mask it to zero.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_oor <= 1'b0;
            end else if (en_ == Enable_ && rw_ == Read) begin
                r_oor <= !w_in_range;
            end
        end

        xpm_memory_spram #(
            .ADDR_WIDTH_A        (ADDR),
            .AUTO_SLEEP_TIME     (0),
            .BYTE_WRITE_WIDTH_A  (LINE),
            .ECC_MODE            ("no_ecc"),
            .MEMORY_INIT_FILE    ("none"),
            .MEMORY_INIT_PARAM   ("0"),
            .MEMORY_OPTIMIZATION ("true"),
            .MEMORY_PRIMITIVE    (PRIM),
            .MEMORY_SIZE         (LINE * DEPTH),
            .MESSAGE_CONTROL     (0),
            .READ_DATA_WIDTH_A   (LINE),
            .READ_LATENCY_A      (1),
            .READ_RESET_VALUE_A  ("0"),
            .RST_MODE_A          ("SYNC"),
            .USE_MEM_INIT        (0),
            .WAKEUP_TIME         ("disable_sleep"),
            .WRITE_DATA_WIDTH_A  (LINE),
            .WRITE_MODE_A        ("no_change")
        ) u_xpm (
            .sleep          (1'b0),
            .clka           (clk),
            .rsta           (reset),
            .ena            (w_ena),
            .regcea         (1'b1),
            .wea            (w_wea),
            .addra          (addr),
            .dina           (wdata),
            .injectsbiterra (1'b0),
            .injectdbiterra (1'b0),
            .douta          (w_douta),
            .sbiterra       (),
            .dbiterra       ()
        );

        assign rdata = r_oor ? {LINE{Low}} : w_douta;
    end else begin : g_model
        ic_ram_model #(
            .LINE  (LINE),
            .DEPTH (DEPTH)
        ) u_ram (
            .clk   (clk),
            .reset (reset),
            .en_   (en_),
            .rw_   (rw_),
            .addr  (addr),
            .wdata (wdata),
            .rdata (rdata)
        );
    end
`else
    // Same RTL model for every target; separate labels keep the
    // hierarchy path distinct per process for constraint files.
    if (PROCESS == XILINX_UP) begin : g_model_up
        ic_ram_model #(
            .LINE  (LINE),
            .DEPTH (DEPTH)
        ) u_ram (
            .clk   (clk),
            .reset (reset),
            .en_   (en_),
            .rw_   (rw_),
            .addr  (addr),
            .wdata (wdata),
            .rdata (rdata)
        );
    end else begin : g_model
        ic_ram_model #(
            .LINE  (LINE),
            .DEPTH (DEPTH)
        ) u_ram (
            .clk   (clk),
            .reset (reset),
            .en_   (en_),
            .rw_   (rw_),
            .addr  (addr),
            .wdata (wdata),
            .rdata (rdata)
        );
    end
`endif

endmodule

// File: tb/tb_icache_ram_block.sv
// Directed self-checking bench for icache_ram_block.
// Covers reset, write/read, idle hold, back-to-back and reset-with-read.
module tb_icache_ram_block;
    import icache_ram_block_pkg::*;

    localparam int LINE  = 128;
    localparam int DEPTH = 1024;
    localparam int ADDR  = $clog2(DEPTH);

    logic            clk;
    logic            reset;
    logic            en_;
    logic            rw_;
    logic [ADDR-1:0] addr;
    logic [LINE-1:0] wdata;
    logic [LINE-1:0] rdata;

    int checks;
    int errors;

    icache_ram_block #(
        .LINE    (LINE),
        .DEPTH   (DEPTH),
        .PROCESS (XILINX_UP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en_   (en_),
        .rw_   (rw_),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic en,
                         input logic rw, input logic [ADDR-1:0] a,
                         input logic [LINE-1:0] d);
        @(negedge clk);
        reset = rst;
        en_   = en;
        rw_   = rw;
        addr  = a;
        wdata = d;
    endtask

    task automatic test_reset();
        drive(1'b1, Disable_, Read, '0, '0);
        step();
        checks++;
        if (rdata !== 128'h0) begin
            $display("FAIL reset_rdata: got %h expected %h",
                     rdata, 128'h0);
            errors++;
        end
        drive(1'b0, Disable_, Read, '0, '0);
        step();
    endtask

    task automatic test_write_read();
        drive(1'b0, Enable_, Write, 10'd0, 128'hdeadbeef);
        step();
        checks++;
        if (rdata !== 128'h0) begin
            $display("FAIL write_no_through: got %h expected %h",
                     rdata, 128'h0);
            errors++;
        end
        drive(1'b0, Enable_, Write, 10'd1, 128'hcafecafe);
        step();
        drive(1'b0, Enable_, Read, 10'd0, '0);
        step();
        checks++;
        if (rdata !== 128'hdeadbeef) begin
            $display("FAIL read_addr0: got %h expected %h",
                     rdata, 128'hdeadbeef);
            errors++;
        end
        drive(1'b0, Enable_, Read, 10'd1, '0);
        step();
        checks++;
        if (rdata !== 128'hcafecafe) begin
            $display("FAIL read_addr1: got %h expected %h",
                     rdata, 128'hcafecafe);
            errors++;
        end
    endtask

    task automatic test_write_then_read();
        drive(1'b0, Enable_, Write, 10'd5, 128'h1234);
        step();
        checks++;
        if (rdata !== 128'hcafecafe) begin
            $display("FAIL write_cycle_hold: got %h expected %h",
                     rdata, 128'hcafecafe);
            errors++;
        end
        drive(1'b0, Enable_, Read, 10'd5, '0);
        step();
        checks++;
        if (rdata !== 128'h1234) begin
            $display("FAIL read_after_write: got %h expected %h",
                     rdata, 128'h1234);
            errors++;
        end
    endtask

    task automatic test_idle_hold();
        drive(1'b0, Enable_, Read, 10'd0, '0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, Disable_, logic'(i[0]), 10'd5,
                  {4{32'h5a5a0000 + 32'(i)}});
            step();
            checks++;
            if (rdata !== 128'hdeadbeef) begin
                $display("FAIL idle_hold_%0d: got %h expected %h",
                         i, rdata, 128'hdeadbeef);
                errors++;
            end
        end
        drive(1'b0, Enable_, Read, 10'd5, '0);
        step();
        checks++;
        if (rdata !== 128'h1234) begin
            $display("FAIL idle_no_write: got %h expected %h",
                     rdata, 128'h1234);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, Enable_, Write, 10'd1023, '1);
        step();
        drive(1'b0, Enable_, Read, 10'd1023, '0);
        step();
        checks++;
        if (rdata !== {LINE{1'b1}}) begin
            $display("FAIL b2b_top: got %h expected %h",
                     rdata, {LINE{1'b1}});
            errors++;
        end
        drive(1'b0, Enable_, Read, 10'd0, '0);
        step();
        checks++;
        if (rdata !== 128'hdeadbeef) begin
            $display("FAIL b2b_zero: got %h expected %h",
                     rdata, 128'hdeadbeef);
            errors++;
        end
    endtask

    task automatic test_reset_with_read();
        drive(1'b1, Enable_, Read, 10'd1, '0);
        step();
        checks++;
        if (rdata !== 128'h0) begin
            $display("FAIL reset_read: got %h expected %h",
                     rdata, 128'h0);
            errors++;
        end
        drive(1'b1, Enable_, Write, 10'd1, 128'h5555);
        step();
        checks++;
        if (rdata !== 128'h0) begin
            $display("FAIL reset_write_rdata: got %h expected %h",
                     rdata, 128'h0);
            errors++;
        end
        drive(1'b0, Enable_, Read, 10'd1, '0);
        step();
        checks++;
        if (rdata !== 128'hcafecafe) begin
            $display("FAIL reset_write_ignored: got %h expected %h",
                     rdata, 128'hcafecafe);
            errors++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        en_    = Disable_;
        rw_    = Read;
        addr   = '0;
        wdata  = '0;
        test_reset();
        test_write_read();
        test_write_then_read();
        test_idle_hold();
        test_back_to_back();
        test_reset_with_read();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
